// File: rtl/wb_ctrl.sv
// Write-back arbiter: merges ALU results and a 2-deep load-result FIFO onto one register-file write port.
// Latency: one cycle from acceptance to rwb_*; pend_mask follows FIFO contents one cycle after push/pop.
// Backpressure: ld_ready drops when the FIFO is full; alu_ready drops only for the single forced-load cycle.
module wb_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_addr,
  input  logic [WIDTH-1:0]           alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  input  logic [WIDTH-1:0]           ld_data,
  output logic                       rwb_we,
  output logic [ADDR_WIDTH-1:0]      rwb_addr,
  output logic [WIDTH-1:0]           rwb_data,
  output logic [(1<<ADDR_WIDTH)-1:0] pend_mask
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  // FIFO storage and control
  logic [ADDR_WIDTH-1:0] fa_q [2];
  logic [WIDTH-1:0]      fd_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [1:0]            starve_q, starve_d;

  // Registered write port and pending mask
  logic                  rwb_we_q;
  logic [ADDR_WIDTH-1:0] rwb_addr_q;
  logic [WIDTH-1:0]      rwb_data_q;
  logic [NREG-1:0]       pend_q, pend_d;

  logic                  fifo_ne, forced, alu_acc, push, pop;
  logic                  win_vld, win_wr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [WIDTH-1:0]      win_data;
  logic                  ent_vld;
  logic [ADDR_WIDTH-1:0] ent_addr;

  // Handshakes and arbitration; reset forces both readies high and blocks all transfers
  always_comb begin
    fifo_ne   = (count_q != 2'd0);
    forced    = fifo_ne && (starve_q == STARVE_LIM);
    alu_ready = rst || !forced;
    ld_ready  = rst || (count_q != 2'd2);
    alu_acc   = !rst && alu_valid && !forced;
    // Head drains when the ALU is idle or when it has been bypassed too long
    pop       = !rst && fifo_ne && (forced || !alu_valid);
    push      = !rst && ld_valid && (count_q != 2'd2);
    win_vld   = alu_acc || pop;
    win_addr  = alu_acc ? alu_addr : fa_q[rd_ptr_q];
    win_data  = alu_acc ? alu_data : fd_q[rd_ptr_q];
    // Writes to register 0 are consumed but never reach the register file
    win_wr    = win_vld && (win_addr != '0);
  end

  // Next-state for FIFO occupancy, pointers and the starvation counter
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (!fifo_ne || pop) begin
      starve_d = 2'd0;
    end else if (alu_acc) begin
      starve_d = starve_q + 2'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Pending mask computed from next-state FIFO contents so it lands with count
  always_comb begin
    pend_d   = '0;
    ent_vld  = 1'b0;
    ent_addr = '0;
    for (int e = 0; e < 2; e++) begin
      ent_vld  = (count_d == 2'd2) || ((count_d == 2'd1) && (rd_ptr_d == e[0]));
      ent_addr = (push && (wr_ptr_q == e[0])) ? ld_addr : fa_q[e];
      if (ent_vld && (ent_addr != '0)) begin
        pend_d[ent_addr] = 1'b1;
      end
    end
  end

  // FIFO payload storage; contents are don't-care until count marks them valid
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wr_ptr_q] <= ld_addr;
      fd_q[wr_ptr_q] <= ld_data;
    end
  end

  // Control state and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      starve_q   <= 2'd0;
      rwb_we_q   <= 1'b0;
      rwb_addr_q <= '0;
      rwb_data_q <= '0;
      pend_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      rwb_we_q <= win_wr;
      pend_q   <= pend_d;
      if (win_wr) begin
        rwb_addr_q <= win_addr;
        rwb_data_q <= win_data;
      end
    end
  end

  assign rwb_we    = rwb_we_q;
  assign rwb_addr  = rwb_addr_q;
  assign rwb_data  = rwb_data_q;
  assign pend_mask = pend_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: one table row per clock cycle, plus a bounded starvation sequence.
// Ready outputs are checked before the edge for that row's inputs; registered outputs just after it.
module tb_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_addr;
  logic [7:0]  alu_data;
  logic        ld_valid, ld_ready;
  logic [3:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        rwb_we;
  logic [3:0]  rwb_addr;
  logic [7:0]  rwb_data;
  logic [15:0] pend_mask;

  int n_checks = 0;
  int n_fail   = 0;

  wb_ctrl #(.ADDR_WIDTH(4), .WIDTH(8), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rwb_we    (rwb_we),
    .rwb_addr  (rwb_addr),
    .rwb_data  (rwb_data),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  aa;
    logic [7:0]  ad;
    logic        lv;
    logic [3:0]  la;
    logic [7:0]  ld;
    logic        e_ardy;
    logic        e_lrdy;
    logic        e_we;
    logic        chk_ad;
    logic [3:0]  e_wa;
    logic [7:0]  e_wd;
    logic [15:0] e_pend;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic av, input logic [3:0] aa, input logic [7:0] ad,
                              input logic lv, input logic [3:0] la, input logic [7:0] ld,
                              input logic ardy, input logic lrdy, input logic we, input logic chk,
                              input logic [3:0] wa, input logic [7:0] wd, input logic [15:0] pend);
    vec_t v;
    v.rst = r;  v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.e_ardy = ardy; v.e_lrdy = lrdy; v.e_we = we; v.chk_ad = chk;
    v.e_wa = wa; v.e_wd = wd; v.e_pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [3:0] aa, input logic [7:0] ad,
                       input logic lv, input logic [3:0] la, input logic [7:0] ld);
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ld;
  endtask

  int n_alu;
  bit seen_forced;

  initial begin
    drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);

    //        rst av aa    ad     lv la    ld     ardy lrdy we chk wa    wd     pend
    // reset
    vt.push_back(mk(1, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h0, 8'h00, 16'h0000));
    // ALU only, then idle hold
    vt.push_back(mk(0, 1, 4'h5, 8'h3C, 0, 4'h0, 8'h00, 1, 1, 1, 1, 4'h5, 8'h3C, 16'h0000));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h5, 8'h3C, 16'h0000));
    // register 0 suppression: ALU, then a load that is buffered and drained
    vt.push_back(mk(0, 1, 4'h0, 8'hFF, 0, 4'h0, 8'h00, 1, 1, 0, 0, 4'h0, 8'h00, 16'h0000));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 1, 4'h0, 8'h44, 1, 1, 0, 0, 4'h0, 8'h00, 16'h0000));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 0, 4'h0, 8'h00, 16'h0000));
    // fill FIFO while ALU busy, third load held, forced pop, held load accepted
    vt.push_back(mk(0, 1, 4'h9, 8'h01, 1, 4'h2, 8'h11, 1, 1, 1, 1, 4'h9, 8'h01, 16'h0004));
    vt.push_back(mk(0, 1, 4'hA, 8'h02, 1, 4'h3, 8'h22, 1, 1, 1, 1, 4'hA, 8'h02, 16'h000C));
    vt.push_back(mk(0, 1, 4'hB, 8'h03, 1, 4'h4, 8'h33, 1, 0, 1, 1, 4'hB, 8'h03, 16'h000C));
    vt.push_back(mk(0, 1, 4'hC, 8'h04, 1, 4'h4, 8'h33, 1, 0, 1, 1, 4'hC, 8'h04, 16'h000C));
    vt.push_back(mk(0, 1, 4'hD, 8'h05, 1, 4'h4, 8'h33, 0, 0, 1, 1, 4'h2, 8'h11, 16'h0008));
    vt.push_back(mk(0, 1, 4'hD, 8'h05, 1, 4'h4, 8'h33, 1, 1, 1, 1, 4'hD, 8'h05, 16'h0018));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 0, 1, 1, 4'h3, 8'h22, 16'h0010));
    // simultaneous push and pop at count 1
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 1, 4'h6, 8'h66, 1, 1, 1, 1, 4'h4, 8'h33, 16'h0040));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 1, 1, 4'h6, 8'h66, 16'h0000));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h6, 8'h66, 16'h0000));
    // starvation: load to r7 buffered with ALU continuously valid
    vt.push_back(mk(0, 1, 4'h1, 8'h10, 1, 4'h7, 8'hA5, 1, 1, 1, 1, 4'h1, 8'h10, 16'h0080));
    vt.push_back(mk(0, 1, 4'h1, 8'h11, 0, 4'h0, 8'h00, 1, 1, 1, 1, 4'h1, 8'h11, 16'h0080));
    vt.push_back(mk(0, 1, 4'h1, 8'h12, 0, 4'h0, 8'h00, 1, 1, 1, 1, 4'h1, 8'h12, 16'h0080));
    vt.push_back(mk(0, 1, 4'h1, 8'h13, 0, 4'h0, 8'h00, 1, 1, 1, 1, 4'h1, 8'h13, 16'h0080));
    vt.push_back(mk(0, 1, 4'h1, 8'h14, 0, 4'h0, 8'h00, 0, 1, 1, 1, 4'h7, 8'hA5, 16'h0000));
    vt.push_back(mk(0, 1, 4'h1, 8'h14, 0, 4'h0, 8'h00, 1, 1, 1, 1, 4'h1, 8'h14, 16'h0000));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h1, 8'h14, 16'h0000));
    // reset with two loads buffered; inputs during reset ignored
    vt.push_back(mk(0, 1, 4'h8, 8'h20, 1, 4'h2, 8'h11, 1, 1, 1, 1, 4'h8, 8'h20, 16'h0004));
    vt.push_back(mk(0, 1, 4'h8, 8'h21, 1, 4'h3, 8'h22, 1, 1, 1, 1, 4'h8, 8'h21, 16'h000C));
    vt.push_back(mk(1, 1, 4'h9, 8'h99, 1, 4'h5, 8'h55, 1, 1, 0, 1, 4'h0, 8'h00, 16'h0000));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h0, 8'h00, 16'h0000));
    vt.push_back(mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h0, 8'h00, 16'h0000));

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].av, vt[i].aa, vt[i].ad, vt[i].lv, vt[i].la, vt[i].ld);
      #1;
      check("alu_ready", i, 32'(alu_ready), 32'(vt[i].e_ardy));
      check("ld_ready",  i, 32'(ld_ready),  32'(vt[i].e_lrdy));
      @(posedge clk);
      #1;
      check("rwb_we",    i, 32'(rwb_we),    32'(vt[i].e_we));
      check("pend_mask", i, 32'(pend_mask), 32'(vt[i].e_pend));
      if (vt[i].chk_ad) begin
        check("rwb_addr", i, 32'(rwb_addr), 32'(vt[i].e_wa));
        check("rwb_data", i, 32'(rwb_data), 32'(vt[i].e_wd));
      end
    end

    // Bounded starvation sequence from the idle post-reset state
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h1, 8'h00, 1'b1, 4'h9, 8'h5A);
    @(posedge clk);
    #1;
    check("seq_pend", 100, 32'(pend_mask), 32'h0000_0200);
    n_alu = 0;
    seen_forced = 1'b0;
    for (int c = 0; c < 10 && !seen_forced; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 4'h1, 8'(c + 1), 1'b0, 4'h0, 8'h00);
      #1;
      if (!alu_ready) seen_forced = 1'b1;
      @(posedge clk);
      #1;
      if (!seen_forced) begin
        n_alu++;
        check("seq_alu_addr", 100 + c, 32'(rwb_addr), 32'h1);
      end
    end
    check("seq_forced_seen", 100, 32'(seen_forced), 32'h1);
    check("seq_alu_writes", 100, 32'(n_alu), 32'd3);
    check("seq_ld_we",   100, 32'(rwb_we),   32'h1);
    check("seq_ld_addr", 100, 32'(rwb_addr), 32'h9);
    check("seq_ld_data", 100, 32'(rwb_data), 32'h5A);
    check("seq_pend_clr", 100, 32'(pend_mask), 32'h0);
    @(negedge clk);
    #1;
    check("seq_alu_resume", 100, 32'(alu_ready), 32'h1);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
